// File: rtl/valid_tagged_ram_pkg.sv
// valid_ram_pkg: shared types and helpers for valid_tagged_ram.
// Holds the flush FSM state encoding, the sweep length calculation and
// the per-cycle occupancy delta used to keep valid_count exact.
package valid_ram_pkg;

    // Flush sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Number of sweep cycles needed to clear every valid bit
    function automatic int flush_cycles(input int depth, input int lanes);
        return depth / lanes;
    endfunction

    // Net change in set valid bits from up to two updates to distinct
    // addresses in one cycle. Each update contributes +1 (0->1),
    // -1 (1->0) or nothing, so the result stays within -2..+2.
    function automatic logic signed [2:0] valid_delta(
        input logic a_en,
        input logic a_old,
        input logic a_new,
        input logic b_en,
        input logic b_old,
        input logic b_new
    );
        logic signed [2:0] d;
        d = 3'sd0;
        if (a_en && a_new && !a_old) d = d + 3'sd1;
        if (a_en && !a_new && a_old) d = d - 3'sd1;
        if (b_en && b_new && !b_old) d = d + 3'sd1;
        if (b_en && !b_new && b_old) d = d - 3'sd1;
        return d;
    endfunction

endpackage

// File: rtl/valid_tagged_ram_ram0.sv
// ram0: payload storage, one write port and one registered read port.
// Reads are read-first: a same-address write in the same cycle is not
// visible until the following read. RAM_TYPE selects how the read is
// structured so the mapping tool picks the intended primitive.
module ram0 #(
    parameter int    WIDTH     = 32,
    parameter int    ADDR_BITS = 7,
    parameter string RAM_TYPE  = "block"
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (RAM_TYPE == "distributed") begin : g_dist
            logic [WIDTH-1:0] rd_comb;
            assign rd_comb = mem[raddr];
            // Asynchronous array read followed by an output register
            always_ff @(posedge clk) begin
                rdata <= rd_comb;
            end
        end else begin : g_block
            // Synchronous read straight from the array
            always_ff @(posedge clk) begin
                rdata <= mem[raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/valid_tagged_ram.sv
// valid_tagged_ram: payload RAM with a per-entry valid bit, a data/valid
// write port A, a valid-only write port B (which also addresses reads),
// consume-on-read, a multi-cycle flush sweep and a live occupancy count.
// Handshake: every request is a single-cycle strobe sampled at the rising
// edge; there is no back-pressure, and while flush_busy is high writes and
// consumes are dropped rather than stalled.
// Optional macro VALID_RAM_BYPASS_EN makes same-address read-during-write
// return the written value (write-first); otherwise reads are read-first.
module valid_tagged_ram
    import valid_ram_pkg::*;
#(
    parameter int    PAYLOAD_BITS  = 32,
    parameter int    NUM_ADDR_BITS = 7,
    parameter int    FLUSH_LANES   = 8,
    parameter string RAM_TYPE      = "block"
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    output logic                     flush_busy,
    input  logic                     wea,
    input  logic [NUM_ADDR_BITS-1:0] addra,
    input  logic [PAYLOAD_BITS:0]    dina,
    input  logic                     web,
    input  logic [NUM_ADDR_BITS-1:0] addrb,
    input  logic [PAYLOAD_BITS:0]    dinb,
    input  logic                     rd_en,
    input  logic                     rd_consume,
    output logic [PAYLOAD_BITS:0]    doutb,
    output logic [NUM_ADDR_BITS:0]   valid_count
);

    localparam int DEPTH        = 1 << NUM_ADDR_BITS;
    localparam int CNT_W        = NUM_ADDR_BITS + 1;
    localparam int FLUSH_CYCLES = flush_cycles(DEPTH, FLUSH_LANES);
    localparam logic [CNT_W-1:0]         LAST_SWEEP = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [NUM_ADDR_BITS-1:0] PTR_STEP   = NUM_ADDR_BITS'(FLUSH_LANES);

    flush_state_t               state;
    logic [NUM_ADDR_BITS-1:0]   ptr;
    logic [CNT_W-1:0]           sweep_idx;
    logic                       busy_q;

    logic [DEPTH-1:0]           valid;
    logic [DEPTH-1:0]           valid_next;
    logic [CNT_W-1:0]           count_q;
    logic [CNT_W-1:0]           count_next;
    logic signed [2:0]          delta;

    logic                       idle;
    logic                       same_ab;
    logic                       a_wr;
    logic                       b_req;
    logic                       b_wr;
    logic                       c_req;
    logic                       c_wr;

    logic                       rd_valid_q;
    logic [PAYLOAD_BITS-1:0]    ram_rdata;
    logic [PAYLOAD_BITS-1:0]    rd_data;

    // Only the valid bit of port B's word carries information
    logic                       unused_dinb;
    assign unused_dinb = ^dinb[PAYLOAD_BITS-1:0];

    // Request qualification; priority A > B > consume on the valid bits.
    // B and consume share addrb, so any B write drops a consume.
    assign idle    = (state == IDLE);
    assign same_ab = (addra == addrb);
    assign a_wr    = wea & idle;
    assign b_req   = web & idle;
    assign b_wr    = b_req & ~(a_wr & same_ab);
    assign c_req   = rd_en & rd_consume & idle;
    assign c_wr    = c_req & ~b_req & ~(a_wr & same_ab);

    // Flush sequencer: sweep FLUSH_LANES entries per cycle, restartable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sweep_idx <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        state     <= FLUSH;
                        ptr       <= '0;
                        sweep_idx <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush) begin
                        ptr       <= '0;
                        sweep_idx <= '0;
                    end else if (sweep_idx == LAST_SWEEP) begin
                        state     <= IDLE;
                        ptr       <= '0;
                        sweep_idx <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        ptr       <= ptr + PTR_STEP;
                        sweep_idx <= sweep_idx + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign flush_busy = busy_q;

    // Next valid array: sweep clears in FLUSH, prioritised updates in IDLE
    always_comb begin
        valid_next = valid;
        if (state == FLUSH) begin
            for (int i = 0; i < FLUSH_LANES; i++) begin
                valid_next[ptr + NUM_ADDR_BITS'(i)] = 1'b0;
            end
        end else begin
            if (c_wr) valid_next[addrb] = 1'b0;
            if (b_wr) valid_next[addrb] = dinb[PAYLOAD_BITS];
            if (a_wr) valid_next[addra] = dina[PAYLOAD_BITS];
        end
    end

    // Valid bit storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) valid <= '0;
        else          valid <= valid_next;
    end

    // Occupancy change this cycle; B and consume never both apply
    always_comb begin
        delta      = valid_delta(a_wr, valid[addra], dina[PAYLOAD_BITS],
                                 b_wr | c_wr, valid[addrb],
                                 b_wr & dinb[PAYLOAD_BITS]);
        count_next = count_q + CNT_W'(delta);
    end

    // Occupancy counter: zeroed on flush and held there during the sweep
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    count_q <= '0;
        else if (flush || state == FLUSH) count_q <= '0;
        else                             count_q <= count_next;
    end

    assign valid_count = count_q;

    ram0 #(
        .WIDTH     (PAYLOAD_BITS),
        .ADDR_BITS (NUM_ADDR_BITS),
        .RAM_TYPE  (RAM_TYPE)
    ) u_ram0 (
        .clk   (clk),
        .we    (a_wr),
        .waddr (addra),
        .wdata (dina[PAYLOAD_BITS-1:0]),
        .raddr (addrb),
        .rdata (ram_rdata)
    );

`ifdef VALID_RAM_BYPASS_EN
    logic                    byp_sel_q;
    logic [PAYLOAD_BITS-1:0] byp_data_q;
    logic                    rd_valid_src;

    // Write-first valid source, same priority as the write path
    always_comb begin
        rd_valid_src = valid[addrb];
        if (a_wr && same_ab) rd_valid_src = dina[PAYLOAD_BITS];
        else if (b_wr)       rd_valid_src = dinb[PAYLOAD_BITS];
    end

    // Registered read valid plus registered data bypass from port A
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_src & idle & ~flush;
            byp_sel_q  <= a_wr & same_ab;
            if (a_wr && same_ab) byp_data_q <= dina[PAYLOAD_BITS-1:0];
        end
    end

    assign rd_data = byp_sel_q ? byp_data_q : ram_rdata;
`else
    // Registered read-first valid bit, forced low once a flush is seen
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_valid_q <= 1'b0;
        else          rd_valid_q <= valid[addrb] & idle & ~flush;
    end

    assign rd_data = ram_rdata;
`endif

    assign doutb = {rd_valid_q, rd_data};

endmodule
